// File: rtl/mod_instruction_fetch_if.sv
// Fetch-stage bus: ROM address/data, decode-side controls and the IF/ID register outputs.
// The master modport is the fetch stage itself; the slave modport is its surroundings.
interface mod_instruction_fetch_if #(
  parameter int ADDR_W = 30
);
  logic [ADDR_W-1:0] imem_address;
  logic [31:0]       imem_instruction;
  logic              imem_end;
  logic              stall;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_target;
  logic              id_valid;
  logic [31:0]       id_instruction;
  logic [ADDR_W-1:0] id_pc;
  logic [ADDR_W-1:0] id_pc_plus1;
  logic              halted;
  logic [31:0]       fetch_count;

  modport master (
    output imem_address,
    input  imem_instruction, imem_end,
    input  stall, redirect_valid, redirect_target,
    output id_valid, id_instruction, id_pc, id_pc_plus1,
    output halted, fetch_count
  );

  modport slave (
    input  imem_address,
    output imem_instruction, imem_end,
    output stall, redirect_valid, redirect_target,
    input  id_valid, id_instruction, id_pc, id_pc_plus1,
    input  halted, fetch_count
  );
endinterface

// File: rtl/mod_instruction_fetch.sv
// Instruction fetch: word-addressed PC driving the ROM, IF/ID register with valid,
// decode stall, branch/jump redirect and halt at the end of the program.
module mod_instruction_fetch #(
  parameter int                ADDR_W   = 30,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mod_instruction_fetch_if.master bus
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt, pc_inc;
  logic              vld_p0, vld_nxt;
  logic              fetch_en;
  logic [31:0]       instr_p0;
  logic [ADDR_W-1:0] pc_p0, pc_plus1_p0;
  logic [31:0]       fetch_count;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign pc_inc = pc + ADDR_W'(1);

  // Priority: redirect > stall > end of program > normal fetch.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    vld_nxt   = vld_p0;
    fetch_en  = 1'b0;
    if (bus.redirect_valid) begin
      pc_nxt    = bus.redirect_target;
      vld_nxt   = 1'b0;
      state_nxt = RUN;
    end else if (state == HALT) begin
      vld_nxt = 1'b0;
    end else if (bus.stall) begin
      vld_nxt = vld_p0;
    end else if (bus.imem_end) begin
      state_nxt = HALT;
      vld_nxt   = 1'b0;
    end else begin
      fetch_en = 1'b1;
      pc_nxt   = pc_inc;
      vld_nxt  = 1'b1;
    end
  end

  // PC -> IF/ID stage boundary
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      pc          <= RESET_PC;
      vld_p0      <= 1'b0;
      instr_p0    <= '0;
      pc_p0       <= '0;
      pc_plus1_p0 <= '0;
      fetch_count <= '0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      vld_p0 <= vld_nxt;
      if (fetch_en) begin
        instr_p0    <= bus.imem_instruction;
        pc_p0       <= pc;
        pc_plus1_p0 <= pc_inc;
        fetch_count <= sat_inc(fetch_count);
      end
    end
  end

  assign bus.imem_address   = pc;
  assign bus.id_valid       = vld_p0;
  assign bus.id_instruction = instr_p0;
  assign bus.id_pc          = pc_p0;
  assign bus.id_pc_plus1    = pc_plus1_p0;
  assign bus.halted         = (state == HALT);
  assign bus.fetch_count    = fetch_count;

endmodule

// File: tb/tb_mod_instruction_fetch.sv
// Scoreboarded bench for mod_instruction_fetch: a 44-word ROM model, directed scenarios
// and randomized stall/redirect/reset traffic checked against a behavioural fetch model.
module tb_mod_instruction_fetch;
  localparam int ADDR_W   = 30;
  localparam int ROM_WORDS = 44;

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic              v;
    logic [31:0]       ins;
    logic [ADDR_W-1:0] ipc;
    logic [ADDR_W-1:0] ipc1;
    logic              halt;
    logic [31:0]       cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic end_off = 1'b0;
  int   total = 0;
  int   bad   = 0;
  exp_t q[$];
  exp_t m;

  mod_instruction_fetch_if #(.ADDR_W(ADDR_W)) bus ();

  mod_instruction_fetch #(.ADDR_W(ADDR_W), .RESET_PC('0)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [ADDR_W-1:0] a);
    if (a == 0)  return 32'h0000_0022;
    if (a == 1)  return 32'h2001_0001;
    if (a == 10) return 32'h1080_0001;
    if (a < ROM_WORDS) return 32'h1000_0000 + 32'(a) * 32'h0001_0003;
    return 32'hDEAD_0000 ^ 32'(a);
  endfunction

  function automatic logic rom_end(input logic [ADDR_W-1:0] a, input logic off);
    return (a >= ROM_WORDS) && !off;
  endfunction

  always_comb begin
    bus.imem_instruction = rom_word(bus.imem_address);
    bus.imem_end         = rom_end(bus.imem_address, end_off);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: drive inputs, advance the reference model, queue the expectation.
  task automatic step(input logic r, input logic s, input logic rv, input logic [ADDR_W-1:0] rt);
    @(negedge clk);
    rst_n = r; bus.stall = s; bus.redirect_valid = rv; bus.redirect_target = rt;
    if (!r) begin
      m.pc = '0; m.v = 0; m.ins = '0; m.ipc = '0; m.ipc1 = '0; m.halt = 0; m.cnt = '0;
    end else if (rv) begin
      m.pc = rt; m.v = 0; m.halt = 0;
    end else if (m.halt) begin
      m.v = 0;
    end else if (s) begin
      // everything holds while decode is stalled
    end else if (rom_end(m.pc, end_off)) begin
      m.halt = 1; m.v = 0;
    end else begin
      m.ins  = rom_word(m.pc);
      m.ipc  = m.pc;
      m.ipc1 = m.pc + 1'b1;
      m.v    = 1;
      m.pc   = m.pc + 1'b1;
      if (m.cnt != 32'hFFFF_FFFF) m.cnt = m.cnt + 1;
    end
    q.push_back(m);
  endtask

  task automatic run_until_pc(input logic [ADDR_W-1:0] target);
    for (int i = 0; i < 200 && m.pc != target; i++) step(1, 0, 0, '0);
    check("reach_pc", 32'(m.pc), 32'(target));
  endtask

  task automatic run_until_halt();
    for (int i = 0; i < 200 && !m.halt; i++) step(1, 0, 0, '0);
    check("reach_halt", 32'(m.halt), 32'd1);
  endtask

  // Monitor: after every rising edge compare the DUT against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        check("imem_address", 32'(bus.imem_address), 32'(e.pc));
        check("id_valid",     32'(bus.id_valid),     32'(e.v));
        check("halted",       32'(bus.halted),       32'(e.halt));
        check("fetch_count",  bus.fetch_count,       e.cnt);
        check("id_instruction", bus.id_instruction,  e.ins);
        check("id_pc",        32'(bus.id_pc),        32'(e.ipc));
        check("id_pc_plus1",  32'(bus.id_pc_plus1),  32'(e.ipc1));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_target = '0;
    m = '{pc: '0, v: 0, ins: '0, ipc: '0, ipc1: '0, halt: 0, cnt: '0};

    // Reset, then free-run the whole program into HALT.
    step(0, 0, 0, '0);
    step(0, 1, 1, 30'd9);
    step(1, 0, 0, '0);
    step(1, 0, 0, '0);
    @(posedge clk); #2;
    check("first_instr", bus.id_instruction, 32'h2001_0001);
    check("first_pc_plus1", 32'(bus.id_pc_plus1), 32'd2);
    run_until_halt();
    for (int i = 0; i < 3; i++) step(1, i[0], 0, '0);
    @(posedge clk); #2;
    check("halt_count", bus.fetch_count, 32'd44);
    check("halt_addr", 32'(bus.imem_address), 32'd44);

    // Redirect out of HALT, then reset while halted.
    step(1, 0, 1, 30'd5);
    step(1, 0, 0, '0);
    run_until_halt();
    step(0, 0, 0, '0);
    step(1, 1, 0, '0);

    // Stall for three cycles at pc=5, then redirect to 10 while stalled at pc=7.
    run_until_pc(30'd5);
    for (int i = 0; i < 3; i++) step(1, 1, 0, '0);
    step(1, 0, 0, '0);
    run_until_pc(30'd7);
    step(1, 1, 1, 30'd10);
    step(1, 0, 0, '0);
    @(posedge clk); #2;
    check("redirect_instr", bus.id_instruction, 32'h1080_0001);

    // Back-to-back redirects, including one issued while the ROM reports end.
    step(1, 0, 1, 30'd50);
    step(1, 0, 1, 30'd3);
    step(1, 1, 1, 30'd20);
    step(1, 0, 0, '0);

    // PC wrap at the top of the address space.
    end_off = 1'b1;
    step(1, 0, 1, 30'h3FFF_FFFF);
    step(1, 0, 0, '0);
    step(1, 0, 0, '0);
    end_off = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      step(r >= 2, $urandom_range(0, 99) < 30, r >= 2 && r < 12,
           ADDR_W'($urandom_range(0, 50)));
    end

    step(1, 0, 0, '0);
    @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
